// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
// Three-port round-robin arbiter in front of a single shared RAM port.
// Each access runs IDLE -> ACCESS -> DONE, so at most one access completes
// every three cycles.
//
// Ports
//   iCLK, iRST            clock, synchronous active-high reset
//   iREQn, iWEn           level request and write(1)/read(0) select, CPU port n
//   iADRn, iWDn           address and write data, CPU port n
//   oACKn                 one-cycle completion pulse, CPU port n
//   oRDn                  read-data latch, CPU port n
//   oGNT                  one-hot grant, 000 while IDLE
//   oRAM_ADR/WE/DO        shared RAM address, write enable, write data
//   iRAM_DI               RAM read data, valid one cycle after the address
//   oSTATE                current arbiter state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Handshake: a port's request is a level. It is sampled only in IDLE, and the
// access then runs to completion whatever the request does afterwards. The
// one-cycle oACKn pulse marks completion; during that pulse the port is not
// eligible, so a request still held one cycle later starts a new access.
module shared_bus_arbiter #(
   parameter int AW = 11,
   parameter int DW = 8
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iREQ0,
   input  logic          iREQ1,
   input  logic          iREQ2,
   input  logic          iWE0,
   input  logic          iWE1,
   input  logic          iWE2,
   input  logic [AW-1:0] iADR0,
   input  logic [AW-1:0] iADR1,
   input  logic [AW-1:0] iADR2,
   input  logic [DW-1:0] iWD0,
   input  logic [DW-1:0] iWD1,
   input  logic [DW-1:0] iWD2,
   output logic          oACK0,
   output logic          oACK1,
   output logic          oACK2,
   output logic [DW-1:0] oRD0,
   output logic [DW-1:0] oRD1,
   output logic [DW-1:0] oRD2,
   output logic [2:0]    oGNT,
   output logic [AW-1:0] oRAM_ADR,
   output logic          oRAM_WE,
   output logic [DW-1:0] oRAM_DO,
   input  logic [DW-1:0] iRAM_DI,
   output logic [1:0]    oSTATE
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [2:0]    gnt_q, gnt_d;
   logic [2:0]    ack_q, ack_d;
   logic          ram_we_q, ram_we_d;
   logic          op_we_q, op_we_d;     // winner's direction, held for DONE
   logic [AW-1:0] ram_adr_q, ram_adr_d;
   logic [DW-1:0] ram_do_q, ram_do_d;
   logic [DW-1:0] rd_q [3];
   logic [DW-1:0] rd_d [3];

   logic [2:0]    req;
   logic [2:0]    elig;
   logic [2:0]    we_in;
   logic [AW-1:0] adr_in [3];
   logic [DW-1:0] wd_in [3];
   logic          win_found;
   logic [1:0]    win_idx;
   logic [2:0]    cand;
   logic [1:0]    gnt_idx;

   assign req       = {iREQ2, iREQ1, iREQ0};
   assign we_in     = {iWE2, iWE1, iWE0};
   assign adr_in[0] = iADR0;
   assign adr_in[1] = iADR1;
   assign adr_in[2] = iADR2;
   assign wd_in[0]  = iWD0;
   assign wd_in[1]  = iWD1;
   assign wd_in[2]  = iWD2;

   // A port whose ack is showing this cycle is masked so a held request
   // is not granted twice back-to-back.
   assign elig = req & ~ack_q;

   // Round-robin search starting at ptr_q, wrapping 2 -> 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 3'd0;
      for (int k = 0; k < 3; k++) begin
         cand = {1'b0, ptr_q} + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!win_found && elig[cand[1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[1:0];
         end
      end
   end

   // Index of the port currently holding the grant.
   always_comb begin
      gnt_idx = 2'd0;
      if (gnt_q[1])      gnt_idx = 2'd1;
      else if (gnt_q[2]) gnt_idx = 2'd2;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      ack_d     = 3'b000;
      ram_we_d  = ram_we_q;
      op_we_d   = op_we_q;
      ram_adr_d = ram_adr_q;
      ram_do_d  = ram_do_q;
      rd_d      = rd_q;
      case (state_q)
         S_IDLE: begin
            gnt_d    = 3'b000;
            ram_we_d = 1'b0;
            if (win_found) begin
               state_d   = S_ACCESS;
               gnt_d     = 3'b001 << win_idx;
               ram_adr_d = adr_in[win_idx];
               ram_do_d  = wd_in[win_idx];
               ram_we_d  = we_in[win_idx];
               op_we_d   = we_in[win_idx];
            end
         end
         S_ACCESS: begin
            // Write strobe lasts exactly the ACCESS cycle.
            state_d  = S_DONE;
            ram_we_d = 1'b0;
         end
         S_DONE: begin
            // iRAM_DI now carries the data for the address set up in ACCESS.
            state_d        = S_IDLE;
            ack_d[gnt_idx] = 1'b1;
            if (!op_we_q) rd_d[gnt_idx] = iRAM_DI;
            ptr_d          = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            gnt_d          = 3'b000;
            ram_we_d       = 1'b0;
         end
         default: begin
            state_d  = S_IDLE;
            gnt_d    = 3'b000;
            ram_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= S_IDLE;
         ptr_q     <= 2'd0;
         gnt_q     <= 3'b000;
         ack_q     <= 3'b000;
         ram_we_q  <= 1'b0;
         op_we_q   <= 1'b0;
         ram_adr_q <= '0;
         ram_do_q  <= '0;
         rd_q      <= '{default: '0};
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         ram_we_q  <= ram_we_d;
         op_we_q   <= op_we_d;
         ram_adr_q <= ram_adr_d;
         ram_do_q  <= ram_do_d;
         rd_q      <= rd_d;
      end
   end

   assign oACK0    = ack_q[0];
   assign oACK1    = ack_q[1];
   assign oACK2    = ack_q[2];
   assign oRD0     = rd_q[0];
   assign oRD1     = rd_q[1];
   assign oRD2     = rd_q[2];
   assign oGNT     = gnt_q;
   assign oRAM_ADR = ram_adr_q;
   assign oRAM_WE  = ram_we_q;
   assign oRAM_DO  = ram_do_q;
   assign oSTATE   = state_q;

endmodule
